// File: rtl/ring_switch_alloc.sv
// -----------------------------------------------------------------------------
// ring_switch_alloc
//   Switch allocator for the 3-port ring router. Drives the one-hot selects of
//   the registered crossbar, arbitrates head flits per output with a
//   round-robin pointer and holds wormhole locks from head to tail. A lock that
//   sees no transfer for MAX_PKT_LEN cycles is forcibly released.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   vld[n]       input n presents a flit on crossbar input i_n
//   hd[n]/tl[n]  input n flit is a head / tail (both set = single-flit packet)
//   dst0..dst2   one-hot output requested by input 0..2 (used on heads only)
//   out_rdy[k]   downstream of output k accepts a flit this cycle
//   sel0..sel2   crossbar select for o0..o2 (one-hot input, 000 = idle)
//   gnt[n]       input n flit transfers at the coming edge
//   out_vld[k]   crossbar output o_k holds a valid flit (registered)
//   err          protocol error or lock timeout this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ring_switch_alloc #(
    parameter int MAX_PKT_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] vld,
    input  logic [2:0] hd,
    input  logic [2:0] tl,
    input  logic [2:0] dst0,
    input  logic [2:0] dst1,
    input  logic [2:0] dst2,
    input  logic [2:0] out_rdy,
    output logic [2:0] sel0,
    output logic [2:0] sel1,
    output logic [2:0] sel2,
    output logic [2:0] gnt,
    output logic [2:0] out_vld,
    output logic       err
);

    localparam int            CW      = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT_LEN);

    // Per-output state, indexed [k]: owner (one-hot input), rr pointer, idle count.
    logic [2:0][2:0]    lock_q, lock_d;
    logic [2:0][2:0]    rr_q, rr_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         out_vld_q, out_vld_d;

    logic [2:0][2:0]    dst;      // dst[n] = destination of input n
    logic [2:0]         owns;     // owns[n]: input n holds some output's lock
    logic [2:0]         dst_ok;   // dst_ok[n]: dst[n] is exactly one-hot
    logic [2:0][2:0]    cand;     // cand[k][n]: input n bids for free output k
    logic [2:0][2:0]    win;      // win[k]: round-robin winner for output k
    logic [2:0][2:0]    sel_c;
    logic               err_c;

    assign dst = {dst2, dst1, dst0};

    // First requester at or after the pointer position, rotating upward.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] ptr);
        logic [2:0] g;
        logic       found;
        int         j;
        g     = '0;
        found = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (ptr[s]) begin
                for (int i = 0; i < 3; i++) begin
                    j = (s + i) % 3;
                    if (!found && req[j]) begin
                        g[j]  = 1'b1;
                        found = 1'b1;
                    end
                end
            end
        end
        return g;
    endfunction

    always_comb begin
        owns = lock_q[0] | lock_q[1] | lock_q[2];
        for (int n = 0; n < 3; n++) begin
            dst_ok[n] = (dst[n] != 3'b000) && ((dst[n] & (dst[n] - 3'b001)) == 3'b000);
        end
    end

    // An input that already owns a lock never bids, so it can win at most one output.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 3; n++) begin
                cand[k][n] = vld[n] & hd[n] & ~owns[n] & dst_ok[n] & dst[n][k];
            end
            win[k] = rr_pick(cand[k], rr_q[k]);
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
        lock_d = lock_q;
        rr_d   = rr_q;
        cnt_d  = cnt_q;
        sel_c  = '0;
        err_c  = 1'b0;

        // Orphan body flits and malformed heads from non-owners are flagged, never granted.
        for (int n = 0; n < 3; n++) begin
            if (vld[n] && !owns[n] && (!hd[n] || !dst_ok[n])) begin
                err_c = 1'b1;
            end
        end

        for (int k = 0; k < 3; k++) begin
            if (lock_q[k] != 3'b000) begin
                if (cnt_q[k] == CNT_MAX) begin
                    // Stuck packet: release the output; its remaining flits become orphans.
                    lock_d[k] = '0;
                    cnt_d[k]  = '0;
                    err_c     = 1'b1;
                end else if (((lock_q[k] & vld) != 3'b000) && out_rdy[k]) begin
                    sel_c[k] = lock_q[k];
                    cnt_d[k] = '0;
                    if ((lock_q[k] & tl) != 3'b000) begin
                        lock_d[k] = '0;
                    end
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end else begin
                cnt_d[k] = '0;
                if ((win[k] != 3'b000) && out_rdy[k]) begin
                    sel_c[k] = win[k];
                    rr_d[k]  = {win[k][1:0], win[k][2]};
                    // Single-flit packets complete in one transfer and take no lock.
                    if ((win[k] & tl) == 3'b000) begin
                        lock_d[k] = win[k];
                    end
                end
            end
        end

        out_vld_d = {|sel_c[2], |sel_c[1], |sel_c[0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q    <= '0;
            rr_q      <= {3{3'b001}};
            cnt_q     <= '0;
            out_vld_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            lock_q    <= lock_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign sel0    = sel_c[0];
    assign sel1    = sel_c[1];
    assign sel2    = sel_c[2];
    assign gnt     = sel_c[0] | sel_c[1] | sel_c[2];
    assign out_vld = out_vld_q;
    assign err     = err_c;

endmodule

// File: tb/tb_ring_switch_alloc.sv
// -----------------------------------------------------------------------------
// tb_ring_switch_alloc
//   Directed scenarios followed by randomized packet traffic for
//   ring_switch_alloc (MAX_PKT_LEN = 4). Expected values come from a
//   behavioural model that tracks owners, pointers and idle counts as integers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ring_switch_alloc;

    localparam int MAXP = 4;

    logic       clk;
    logic       rst;
    logic [2:0] vld, hd, tl, out_rdy;
    logic [2:0] dst_a [3];
    logic [2:0] dst0, dst1, dst2;
    logic [2:0] sel0, sel1, sel2, gnt, out_vld;
    logic       err;

    assign dst0 = dst_a[0];
    assign dst1 = dst_a[1];
    assign dst2 = dst_a[2];

    ring_switch_alloc #(.MAX_PKT_LEN(MAXP)) dut (
        .clk     (clk),
        .rst     (rst),
        .vld     (vld),
        .hd      (hd),
        .tl      (tl),
        .dst0    (dst0),
        .dst1    (dst1),
        .dst2    (dst2),
        .out_rdy (out_rdy),
        .sel0    (sel0),
        .sel1    (sel1),
        .sel2    (sel2),
        .gnt     (gnt),
        .out_vld (out_vld),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner input per output (-1 = free), pointer index, idle cycles.
    int         m_owner [3];
    int         m_ptr   [3];
    int         m_idle  [3];
    logic [2:0] m_ovld;
    int         x_owner [3];
    int         x_ptr   [3];
    int         x_idle  [3];
    logic [2:0] x_ovld;
    int         e_sel   [3];
    logic [2:0] e_gnt;
    logic       e_err;

    // Random traffic sources.
    int         left    [3];
    bit         started [3];
    logic [2:0] pdst    [3];

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] enc(input int s);
        logic [2:0] one;
        one = 3'b001;
        return (s < 0) ? 3'b000 : (one << s);
    endfunction

    function automatic bit m_owns(input int n);
        bit r;
        r = 1'b0;
        for (int k = 0; k < 3; k++) if (m_owner[k] == n) r = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_idle[k]  = 0;
        end
        m_ovld = 3'b000;
    endtask

    task automatic model_eval();
        bit owns [3];
        int o;
        int n;
        int w;
        e_err = 1'b0;
        e_gnt = 3'b000;
        for (int i = 0; i < 3; i++) owns[i] = m_owns(i);
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && !owns[i] && (!hd[i] || $countones(dst_a[i]) != 1)) e_err = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            e_sel[k]   = -1;
            x_owner[k] = m_owner[k];
            x_ptr[k]   = m_ptr[k];
            x_idle[k]  = 0;
            if (m_owner[k] >= 0) begin
                o = m_owner[k];
                if (m_idle[k] == MAXP) begin
                    x_owner[k] = -1;
                    e_err      = 1'b1;
                end else if (vld[o] && out_rdy[k]) begin
                    e_sel[k] = o;
                    if (tl[o]) x_owner[k] = -1;
                end else begin
                    x_idle[k] = m_idle[k] + 1;
                end
            end else begin
                w = -1;
                for (int i = 0; i < 3; i++) begin
                    n = (m_ptr[k] + i) % 3;
                    if (w < 0 && vld[n] && hd[n] && !owns[n] &&
                        $countones(dst_a[n]) == 1 && dst_a[n][k]) w = n;
                end
                if (w >= 0 && out_rdy[k]) begin
                    e_sel[k] = w;
                    x_ptr[k] = (w + 1) % 3;
                    if (!tl[w]) x_owner[k] = w;
                end
            end
            x_ovld[k] = (e_sel[k] >= 0);
            if (e_sel[k] >= 0) e_gnt[e_sel[k]] = 1'b1;
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] h, input logic [2:0] t,
                         input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] rdy);
        vld      = v;
        hd       = h;
        tl       = t;
        dst_a[0] = d0;
        dst_a[1] = d1;
        dst_a[2] = d2;
        out_rdy  = rdy;
    endtask

    task automatic eval_check(input string tag);
        #1;
        model_eval();
        check({tag, "/sel0"}, sel0, enc(e_sel[0]));
        check({tag, "/sel1"}, sel1, enc(e_sel[1]));
        check({tag, "/sel2"}, sel2, enc(e_sel[2]));
        check({tag, "/gnt"}, gnt, e_gnt);
        check({tag, "/err"}, {2'b00, err}, {2'b00, e_err});
        check({tag, "/out_vld"}, out_vld, m_ovld);
    endtask

    task automatic tick();
        @(posedge clk);
        m_owner = x_owner;
        m_ptr   = x_ptr;
        m_idle  = x_idle;
        m_ovld  = x_ovld;
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
        model_reset();
        #1;
        check({tag, "/out_vld"}, out_vld, 3'b000);
        check({tag, "/err"}, {2'b00, err}, 3'b000);
        check({tag, "/sel0"}, sel0, 3'b000);
        check({tag, "/sel1"}, sel1, 3'b000);
        check({tag, "/sel2"}, sel2, 3'b000);
        check({tag, "/gnt"}, gnt, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic gen_random();
        logic [2:0] one;
        int         r;
        one = 3'b001;
        for (int n = 0; n < 3; n++) begin
            if (left[n] == 0 || (!started[n] && $urandom_range(0, 9) == 0)) begin
                left[n]    = $urandom_range(1, 4);
                started[n] = 1'b0;
                r          = $urandom_range(0, 15);
                if (r == 0)      pdst[n] = 3'b011;
                else if (r == 1) pdst[n] = 3'b000;
                else             pdst[n] = one << $urandom_range(0, 2);
            end
            vld[n]   = ($urandom_range(0, 9) < 8);
            hd[n]    = !started[n];
            tl[n]    = (left[n] == 1);
            dst_a[n] = started[n] ? 3'($urandom_range(0, 7)) : pdst[n];
        end
        for (int k = 0; k < 3; k++) out_rdy[k] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic update_sources();
        for (int n = 0; n < 3; n++) begin
            if (e_gnt[n]) begin
                started[n] = 1'b1;
                left[n]    = left[n] - 1;
                if (left[n] == 0) started[n] = 1'b0;
            end else if (started[n] && !m_owns(n) && $urandom_range(0, 1) == 1) begin
                // Lock was lost to a timeout; the source eventually abandons the packet.
                left[n]    = 0;
                started[n] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < 3; n++) begin
            left[n]    = 0;
            started[n] = 1'b0;
            pdst[n]    = 3'b001;
        end

        // Power-on reset.
        do_reset("reset0");

        // Open a packet in0 -> o1, then reset in the middle of it.
        drive(3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000, 3'b111);
        eval_check("pre_head");
        check("pre_head/sel1_const", sel1, 3'b001);
        tick();
        drive(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
        eval_check("pre_body");
        tick();
        do_reset("reset_mid");

        // The leftover body flit is now an orphan.
        drive(3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b111);
        eval_check("orphan_after_reset");
        check("orphan_after_reset/err_const", {2'b00, err}, 3'b001);
        check("orphan_after_reset/gnt_const", gnt, 3'b000);
        tick();

        // Single-flit packet in0 -> o1.
        drive(3'b001, 3'b001, 3'b001, 3'b010, 3'b000, 3'b000, 3'b111);
        eval_check("single");
        check("single/sel1_const", sel1, 3'b001);
        check("single/gnt_const", gnt, 3'b001);
        tick();
        drive(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
        eval_check("single_next");
        check("single_next/out_vld_const", out_vld, 3'b010);
        tick();

        // Three single-flit requesters on o2 take turns.
        for (int c = 0; c < 3; c++) begin
            drive(3'b111, 3'b111, 3'b111, 3'b100, 3'b100, 3'b100, 3'b111);
            eval_check($sformatf("contend%0d", c));
            check($sformatf("contend%0d/sel2_const", c), sel2, enc(c));
            tick();
        end

        // Wormhole: in1 4-flit packet to o0, in2 single-flit head to o0 waits.
        for (int c = 0; c < 4; c++) begin
            drive(3'b110, (c == 0) ? 3'b110 : 3'b100, (c == 3) ? 3'b110 : 3'b100,
                  3'b000, 3'b001, 3'b001, 3'b111);
            eval_check($sformatf("worm%0d", c));
            check($sformatf("worm%0d/sel0_const", c), sel0, 3'b010);
            tick();
        end
        drive(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001, 3'b111);
        eval_check("worm_after_tail");
        check("worm_after_tail/sel0_const", sel0, 3'b100);
        tick();

        // Backpressure then bubble in the middle of an in1 -> o0 packet.
        drive(3'b010, 3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b111);
        eval_check("bp_head");
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b110);
            eval_check($sformatf("bp_stall%0d", c));
            check($sformatf("bp_stall%0d/sel0_const", c), sel0, 3'b000);
            check($sformatf("bp_stall%0d/gnt_const", c), gnt, 3'b000);
            tick();
        end
        drive(3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b111);
        eval_check("bp_bubble");
        check("bp_bubble/sel0_const", sel0, 3'b000);
        tick();
        drive(3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b111);
        eval_check("bp_body");
        check("bp_body/sel0_const", sel0, 3'b010);
        tick();
        drive(3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b111);
        eval_check("bp_tail");
        check("bp_tail/sel0_const", sel0, 3'b010);
        tick();

        // Lock timeout: in0 head to o1, then silence.
        drive(3'b001, 3'b001, 3'b000, 3'b010, 3'b000, 3'b000, 3'b111);
        eval_check("to_head");
        check("to_head/sel1_const", sel1, 3'b001);
        tick();
        for (int c = 1; c <= MAXP + 1; c++) begin
            drive(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
            eval_check($sformatf("to_idle%0d", c));
            check($sformatf("to_idle%0d/err_const", c), {2'b00, err}, (c == MAXP + 1) ? 3'b001 : 3'b000);
            tick();
        end
        drive(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111);
        eval_check("to_quiet");
        check("to_quiet/err_const", {2'b00, err}, 3'b000);
        tick();
        drive(3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b111);
        eval_check("to_orphan");
        check("to_orphan/err_const", {2'b00, err}, 3'b001);
        check("to_orphan/gnt_const", gnt, 3'b000);
        tick();
        drive(3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b010, 3'b111);
        eval_check("to_free");
        check("to_free/sel1_const", sel1, 3'b100);
        tick();

        // Randomized packet traffic against the model.
        for (int c = 0; c < 800; c++) begin
            gen_random();
            eval_check("rnd");
            tick();
            update_sources();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
